stream_min_max: RTL

Windowed min/max tracker. It sits directly downstream of the existing N-bit magnitude comparator.
- Accepts a stream of unsigned N-bit samples over a valid/ready handshake.
- Compares each sample against running minimum and maximum registers using two comparator instances.
- After every WIN samples, presents min, max and the number of samples equal to the final max on a valid/ready output port.

---
 rtl/smm_pkg.sv | 19 +
 rtl/n_bit_comp.sv | 19 +
 rtl/stream_min_max.sv | 126 ++++++++++++
 3 files changed

// File: rtl/smm_pkg.sv
// Shared types and helpers for the windowed min/max tracker.
package smm_pkg;

  // Window controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for the first sample of a window
    ACCUM = 2'd1,  // collecting the remaining samples
    HOLD  = 2'd2   // result presented, waiting for the consumer
  } state_t;

  // Number of bits needed to hold the value 'value' (equivalent to $clog2(value+1)).
  function automatic int cnt_width(input int value);
    int w;
    w = 1;
    while ((64'd1 << w) <= 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/n_bit_comp.sv
// Unsigned N-bit magnitude comparator: flags a > b, a < b and a == b.
module n_bit_comp #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt,
  output logic         lt,
  output logic         eq
);

  // Pure combinational compare of the two unsigned operands.
  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/stream_min_max.sv
// Windowed min/max tracker: collects WIN samples, then presents the window's
// minimum, maximum and the number of samples equal to that maximum.
module stream_min_max
  import smm_pkg::*;
#(
  parameter  int N     = 32,
  parameter  int WIN   = 8,
  localparam int CNT_W = cnt_width(WIN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_min,
  output logic [N-1:0]     out_max,
  output logic [CNT_W-1:0] out_max_cnt
);

  // The window is complete on the accept that is made while WIN-1 samples are held.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);

  state_t           state_q, state_d;
  logic [N-1:0]     min_q, max_q;
  logic [CNT_W-1:0] max_cnt_q;
  logic [CNT_W-1:0] sample_cnt_q;

  logic accept;
  logic last_sample;
  logic min_gt, min_lt, min_eq;
  logic max_gt, max_lt, max_eq;
  logic cmp_unused;

  // Handshake and window-position decodes; ready/valid come from the state register only.
  always_comb begin
    in_ready    = (state_q != HOLD);
    out_valid   = (state_q == HOLD);
    accept      = in_valid && in_ready;
    last_sample = (sample_cnt_q == LAST_CNT);
  end

  // New sample against the registered running minimum (only LT is needed).
  n_bit_comp #(.N(N)) u_min_comp (
    .a  (in_data),
    .b  (min_q),
    .gt (min_gt),
    .lt (min_lt),
    .eq (min_eq)
  );

  // New sample against the registered running maximum (GT replaces, EQ counts a tie).
  n_bit_comp #(.N(N)) u_max_comp (
    .a  (in_data),
    .b  (max_q),
    .gt (max_gt),
    .lt (max_lt),
    .eq (max_eq)
  );

  assign cmp_unused = &{1'b0, min_gt, min_eq, max_lt};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACCUM;
      ACCUM:   if (accept && last_sample) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Running min/max, tie counter and sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so outputs read 0 straight out of reset.
      min_q        <= '0;
      max_q        <= '0;
      max_cnt_q    <= '0;
      sample_cnt_q <= '0;
    end else if (clear) begin
      // A sample offered alongside clear is dropped; data registers may keep stale values.
      sample_cnt_q <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments here so every compare uses the pre-edge running values.
      sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      if (state_q == IDLE) begin
        min_q     <= in_data;
        max_q     <= in_data;
        max_cnt_q <= CNT_W'(1);
      end else begin
        if (min_lt) min_q <= in_data;
        if (max_gt) begin
          max_q     <= in_data;
          max_cnt_q <= CNT_W'(1);
        end else if (max_eq) begin
          max_cnt_q <= max_cnt_q + CNT_W'(1);
        end
      end
    end else if ((state_q == HOLD) && out_ready) begin
      sample_cnt_q <= '0;
    end
  end

  // Outside HOLD these expose the running registers; consumers qualify with out_valid.
  always_comb begin
    out_min     = min_q;
    out_max     = max_q;
    out_max_cnt = max_cnt_q;
  end

endmodule
